// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_WIDTH        = 32;
    localparam int MULDIV_LATENCY_ITER = 33;
    localparam int MULDIV_LATENCY_FAST = 1;
    localparam logic [31:0] MULDIV_DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_t;

    function automatic logic f_is_mul(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic f_is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic f_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH);
    import muldiv_pkg::*;

    logic             op_valid;
    logic             op_ready;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, a, b,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, a, b,
        output op_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring shift-subtract divide
// on unsigned magnitudes, plus the iteration counter.
module muldiv_iter_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic                 i_is_div,
    input  logic [WIDTH-1:0]     i_opa,
    input  logic [WIDTH-1:0]     i_opb,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_prod,
    output logic [WIDTH-1:0]     o_quot,
    output logic [WIDTH-1:0]     o_rem
);
    localparam int CW = $clog2(ITER + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_addend;
    logic               r_is_div;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;

    // Multiplier lives in r_acc low half, multiplicand in r_addend.
    // Dividend/quotient shares r_acc low half, divisor in r_addend.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_addend} : {(WIDTH+1){1'b0}});
    assign w_trial   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_addend};

    // Load operands on start, otherwise advance one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_addend <= {WIDTH{1'b0}};
            r_is_div <= 1'b0;
            r_cnt    <= {CW{1'b0}};
        end else if (i_start) begin
            r_is_div <= i_is_div;
            r_addend <= i_is_div ? i_opb : i_opa;
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_opa : i_opb)};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (i_step) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_is_div) begin
                if (!w_diff[WIDTH]) begin
                    r_rem              <= w_diff;
                    r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem              <= w_trial;
                    r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_last = (r_cnt == CW'(ITER - 1));
    assign o_prod = r_acc;
    assign o_quot = r_acc[WIDTH-1:0];
    assign o_rem  = r_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner for the MIPS execute stage: MULT/MULTU/DIV/DIVU/MTHI/MTLO via valid/ready.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    muldiv_state_t      r_state;
    muldiv_state_t      w_next_state;
    muldiv_op_t         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_busy;

    logic               w_accept;
    logic               w_in_mul;
    logic               w_in_div;
    logic               w_in_signed;
    logic               w_core_start;
    logic               w_core_step;
    logic               w_core_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_core_prod;
    logic [WIDTH-1:0]   w_core_quot;
    logic [WIDTH-1:0]   w_core_rem;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE) : v;
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    assign w_fast_prod = {{WIDTH{1'b0}}, f_mag(r_a, r_signed)}
                       * {{WIDTH{1'b0}}, f_mag(r_b, r_signed)};
`else
    localparam logic FAST_MUL = 1'b0;
    assign w_fast_prod = {(2*WIDTH){1'b0}};
`endif

    assign w_accept    = bus.op_valid && (r_state == ST_IDLE);
    assign w_in_mul    = f_is_mul(bus.op);
    assign w_in_div    = f_is_div(bus.op);
    assign w_in_signed = f_is_signed(bus.op);
    assign w_mag_a     = f_mag(bus.a, w_in_signed);
    assign w_mag_b     = f_mag(bus.b, w_in_signed);

    muldiv_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_start  (w_core_start),
        .i_step   (w_core_step),
        .i_is_div (w_in_div),
        .i_opa    (w_mag_a),
        .i_opb    (w_mag_b),
        .o_last   (w_core_last),
        .o_prod   (w_core_prod),
        .o_quot   (w_core_quot),
        .o_rem    (w_core_rem)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and core control.
    always_comb begin
        w_next_state = r_state;
        w_core_start = 1'b0;
        w_core_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_in_mul || w_in_div)) begin
                    w_core_start = 1'b1;
                    if (FAST_MUL && w_in_mul) begin
                        w_next_state = ST_FIX;
                    end else begin
                        w_next_state = ST_CALC;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_core_step = 1'b1;
                if (w_core_last) begin
                    w_next_state = ST_FIX;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sign fix-up and divide special cases applied in the FIX cycle.
    always_comb begin
        w_prod_mag = (FAST_MUL && f_is_mul(r_op)) ? w_fast_prod : w_core_prod;
        w_prod     = r_neg_q ? (~w_prod_mag + {{WIDTH{1'b0}}, ONE}) : w_prod_mag;
        w_res_hi   = r_hi;
        w_res_lo   = r_lo;
        if (f_is_mul(r_op)) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_b == ZERO) begin
            w_res_hi = r_a;
            w_res_lo = ALL1;
        end else if ((r_op == OP_DIV) && (r_a == MOST_NEG) && (r_b == ALL1)) begin
            w_res_hi = ZERO;
            w_res_lo = MOST_NEG;
        end else begin
            w_res_hi = r_neg_r ? (~w_core_rem + ONE) : w_core_rem;
            w_res_lo = r_neg_q ? (~w_core_quot + ONE) : w_core_quot;
        end
    end

    // Latch the accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= OP_NONE;
            r_a      <= ZERO;
            r_b      <= ZERO;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_signed <= w_in_signed;
            r_neg_q  <= w_in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_in_signed && bus.a[WIDTH-1];
        end else begin
            r_op     <= r_op;
        end
    end

    // Architectural HI/LO: updated only by FIX or a move.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= ZERO;
            r_lo <= ZERO;
        end else if (r_state == ST_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_accept && (bus.op == OP_MTHI)) begin
            r_hi <= bus.a;
        end else if (w_accept && (bus.op == OP_MTLO)) begin
            r_lo <= bus.a;
        end else begin
            r_hi <= r_hi;
        end
    end

    // busy covers CALC and the FIX that follows it; done marks first visible cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_CALC)
                   || ((w_next_state == ST_FIX) && (r_state == ST_CALC));
            r_done <= (r_state == ST_FIX);
        end
    end

    assign bus.op_ready = (r_state == ST_IDLE);
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; follows MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = MULDIV_LATENCY_FAST;
`else
    localparam int MUL_LAT = MULDIV_LATENCY_ITER;
`endif
    localparam int DIV_LAT = MULDIV_LATENCY_ITER;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Issue one op at the current negedge and follow it to done.
    task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string name, input bit check_tail);
        int lat = 0;
        bit seen_busy = 1'b0;
        bit ready_low = 1'b1;
        bit moved = 1'b0;
        n_vec++;
        if (bus.op_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_before: got %b expected 1", name, bus.op_ready);
        end
        bus.op_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = OP_NONE;
        if (bus.busy === 1'b1) seen_busy = 1'b1;
        if (bus.op_ready !== 1'b0) ready_low = 1'b0;
        if (bus.done === 1'b1) moved = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy === 1'b1) seen_busy = 1'b1;
            if (bus.op_ready !== 1'b0) ready_low = 1'b0;
            if ((bus.hi !== m_hi) || (bus.lo !== m_lo)) moved = 1'b1;
        end
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
        end
        n_vec++;
        if (moved !== 1'b0) begin
            n_err++; $display("FAIL %s hold: hi/lo or done changed early, got 1 expected 0", name);
        end
        n_vec++;
        if (ready_low !== 1'b1) begin
            n_err++; $display("FAIL %s ready_low: got %b expected 1", name, ready_low);
        end
        n_vec++;
        if (seen_busy !== (exp_lat > 1)) begin
            n_err++; $display("FAIL %s busy_seen: got %b expected %b", name, seen_busy, (exp_lat > 1));
        end
        n_vec++;
        if (bus.hi !== exp_hi) begin
            n_err++; $display("FAIL %s hi: got %h expected %h", name, bus.hi, exp_hi);
        end
        n_vec++;
        if (bus.lo !== exp_lo) begin
            n_err++; $display("FAIL %s lo: got %h expected %h", name, bus.lo, exp_lo);
        end
        n_vec++;
        if ((bus.busy !== 1'b0) || (bus.op_ready !== 1'b1)) begin
            n_err++; $display("FAIL %s done_cycle busy/ready: got %b/%b expected 0/1", name, bus.busy, bus.op_ready);
        end
        m_hi = exp_hi;
        m_lo = exp_lo;
        if (check_tail) begin
            @(negedge clk);
            n_vec++;
            if (bus.done !== 1'b0) begin
                n_err++; $display("FAIL %s done_pulse: got %b expected 0 one cycle later", name, bus.done);
            end
        end
    endtask

    task automatic test_reset();
        bus.op_valid = 1'b0; bus.op = OP_NONE; bus.a = 32'h0; bus.b = 32'h0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            n_err++; $display("FAIL reset hi/lo: got %h expected 0", {bus.hi, bus.lo});
        end
        n_vec++;
        if ({bus.busy, bus.done, bus.op_ready} !== 3'b001) begin
            n_err++; $display("FAIL reset busy/done/ready: got %b expected 001", {bus.busy, bus.done, bus.op_ready});
        end
        m_hi = 32'h0; m_lo = 32'h0;
    endtask

    task automatic test_multiply();
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1);
        do_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg", 1'b1);
        do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000, "mult_minsq", 1'b1);
    endtask

    task automatic test_divide();
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a", 1'b1);
        do_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, "div_neg_b", 1'b1);
        do_op(OP_DIVU, 32'd64,        32'd7,         DIV_LAT, 32'h0000_0001, 32'h0000_0009, "divu_64_7", 1'b1);
    endtask

    task automatic test_div_special();
        do_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000, DIV_LAT, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0", 1'b1);
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0", 1'b1);
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000, "div_ovf", 1'b1);
    endtask

    task automatic test_moves();
        bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.a = 32'hA5A5_0F0F;
        @(posedge clk); @(negedge clk);
        bus.op = OP_MTLO; bus.a = 32'hCAFE_BABE;
        n_vec++;
        if ({bus.hi, bus.lo} !== {32'hA5A5_0F0F, m_lo}) begin
            n_err++; $display("FAIL mthi: got %h expected %h", {bus.hi, bus.lo}, {32'hA5A5_0F0F, m_lo});
        end
        n_vec++;
        if ({bus.busy, bus.done, bus.op_ready} !== 3'b001) begin
            n_err++; $display("FAIL mthi busy/done/ready: got %b expected 001", {bus.busy, bus.done, bus.op_ready});
        end
        @(posedge clk); @(negedge clk);
        bus.op = OP_RSVD; bus.a = 32'h1111_2222; bus.b = 32'h3333_4444;
        n_vec++;
        if ({bus.hi, bus.lo} !== 64'hA5A5_0F0F_CAFE_BABE) begin
            n_err++; $display("FAIL mtlo: got %h expected a5a50f0fcafebabe", {bus.hi, bus.lo});
        end
        @(posedge clk); @(negedge clk);
        bus.op = OP_NONE;
        @(posedge clk); @(negedge clk);
        bus.op_valid = 1'b0;
        n_vec++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.op_ready} !== {64'hA5A5_0F0F_CAFE_BABE, 3'b001}) begin
            n_err++; $display("FAIL rsvd_none: got %h/%b expected a5a50f0fcafebabe/001",
                              {bus.hi, bus.lo}, {bus.busy, bus.done, bus.op_ready});
        end
        m_hi = 32'hA5A5_0F0F; m_lo = 32'hCAFE_BABE;
    endtask

    task automatic test_back_to_back();
        do_op(OP_DIVU,  32'd100, 32'd9,  DIV_LAT, 32'h0000_0001, 32'h0000_000B, "b2b_divu", 1'b0);
        do_op(OP_MULTU, 32'd10,  32'd20, MUL_LAT, 32'h0000_0000, 32'h0000_00C8, "b2b_multu", 1'b1);
    endtask

    task automatic test_busy_ignore_and_reset();
        bit saw_done = 1'b0;
        bus.op_valid = 1'b1; bus.op = OP_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'h0000_0002;
        @(posedge clk); @(negedge clk);
        bus.op_valid = 1'b0; bus.op = OP_NONE;
        repeat (4) @(negedge clk);
        bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = OP_NONE;
        n_vec++;
        if (bus.hi !== m_hi) begin
            n_err++; $display("FAIL mthi_while_busy: got %h expected %h", bus.hi, m_hi);
        end
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            n_err++; $display("FAIL midop_reset hi/lo: got %h expected 0", {bus.hi, bus.lo});
        end
        n_vec++;
        if ({bus.busy, bus.done, bus.op_ready} !== 3'b001) begin
            n_err++; $display("FAIL midop_reset busy/done/ready: got %b expected 001", {bus.busy, bus.done, bus.op_ready});
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = 32'h0; m_lo = 32'h0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++; $display("FAIL no_done_after_reset: got 1 expected 0");
        end
        bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        bus.op_valid = 1'b0; bus.op = OP_NONE;
        n_vec++;
        if ({bus.hi, bus.lo} !== 64'h1234_5678_0000_0000) begin
            n_err++; $display("FAIL mthi_after_reset: got %h expected 1234567800000000", {bus.hi, bus.lo});
        end
        m_hi = 32'h1234_5678;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_special();
        test_moves();
        test_back_to_back();
        test_busy_ignore_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
